// File: rtl/alu_mul_sequencer.sv
// Shift-and-add sequencer producing the low 32 bits of a 32x32 multiply by
// time-sharing the EX-stage ALU (add and logical-left-shift only).
module alu_mul_sequencer (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  input  logic [31:0] alu_result_i,
  output logic [3:0]  alu_op_o,
  output logic [31:0] alu_in_1_o,
  output logic [31:0] alu_in_2_o,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] product_o
);

  // ALU function codes shared with the ALU decoder.
  localparam logic [3:0] FuncAdd = 4'd0;
  localparam logic [3:0] FuncLls = 4'd1;

  typedef enum logic [1:0] {
    StIdle,
    StAdd,
    StShift,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] acc_q, acc_d;

  always_comb begin
    state_d    = state_q;
    mcand_d    = mcand_q;
    mplier_d   = mplier_q;
    acc_d      = acc_q;
    alu_op_o   = FuncAdd;
    alu_in_1_o = 32'd0;
    alu_in_2_o = 32'd0;
    busy_o     = (state_q != StIdle);
    done_o     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          mcand_d  = operand_a_i;
          mplier_d = operand_b_i;
          acc_d    = 32'd0;
          state_d  = (operand_b_i == 32'd0) ? StDone : StAdd;
        end
      end
      StAdd: begin
        alu_op_o   = FuncAdd;
        alu_in_1_o = acc_q;
        alu_in_2_o = mplier_q[0] ? mcand_q : 32'd0;
        acc_d      = alu_result_i;
        state_d    = StShift;
      end
      StShift: begin
        alu_op_o   = FuncLls;
        alu_in_1_o = mcand_q;
        alu_in_2_o = 32'd1;
        mcand_d    = alu_result_i;
        mplier_d   = mplier_q >> 1;
        // Terminate as soon as no set multiplier bits remain.
        state_d    = (mplier_q[31:1] == 31'd0) ? StDone : StAdd;
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= StIdle;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      acc_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign product_o = acc_q;

endmodule
